// File: rtl/mem_responder.sv
// Latency-modelled word memory with tagged loads, posted stores and a busy-tag tracker.
// Optional MEM_RESPONDER_ALIGN_CHECK_EN rejects accesses with addr[2:0] != 0 and raises err_misaligned.
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package mem_responder_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;
endpackage

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 16,
  parameter int unsigned MEM_DEPTH   = 4096
) (
  input  logic                             clock,
  input  logic                             reset,
  input  BUS_COMMAND                       proc2mem_command,
  input  logic [31:0]                      proc2mem_addr,
  input  logic [`DATA_SIZE-1:0]            proc2mem_data,
  output logic [$clog2(`NUM_MEM_TAGS)-1:0] mem2proc_response,
  output logic [`DATA_SIZE-1:0]            mem2proc_data,
  output logic [$clog2(`NUM_MEM_TAGS)-1:0] mem2proc_tag,
  output logic                             err_misaligned
);

  localparam int unsigned NTAGS = `NUM_MEM_TAGS;
  localparam int unsigned TAG_W = $clog2(`NUM_MEM_TAGS);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

  logic [`DATA_SIZE-1:0] mem  [0:MEM_DEPTH-1];
  logic [`DATA_SIZE-1:0] snap [1:NTAGS];
  logic [CNT_W-1:0]      count[1:NTAGS];
  logic [NTAGS:1]        busy;

  logic [IDX_W-1:0] word_idx;
  logic             addr_ok;
  logic             free_found;
  logic [TAG_W-1:0] free_tag;
  logic             ret_found;
  logic [TAG_W-1:0] ret_tag;
  logic             load_acc;
  logic             store_acc;
  logic             unused_addr;

  assign word_idx    = proc2mem_addr[3+IDX_W-1:3];
  assign unused_addr = ^{proc2mem_addr[31:3+IDX_W], proc2mem_addr[2:0]};

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign addr_ok = (proc2mem_addr[2:0] == 3'b000);
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    ret_found  = 1'b0;
    ret_tag    = '0;
    for (int unsigned t = 1; t <= NTAGS; t++) begin
      if (!busy[TAG_W'(t)] && !free_found) begin
        free_found = 1'b1;
        free_tag   = TAG_W'(t);
      end
      // A count of 2 means the tag must be visible on mem2proc_tag next cycle.
      if (count[TAG_W'(t)] == CNT_W'(2) && !ret_found) begin
        ret_found = 1'b1;
        ret_tag   = TAG_W'(t);
      end
    end
  end

  always_comb begin
    load_acc          = !reset && (proc2mem_command == BUS_LOAD) && free_found && addr_ok;
    store_acc         = !reset && (proc2mem_command == BUS_STORE) && addr_ok;
    mem2proc_response = '0;
    if (load_acc)
      mem2proc_response = free_tag;
    else if (store_acc)
      mem2proc_response = free_found ? free_tag : TAG_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy          <= '0;
      mem2proc_tag  <= '0;
      mem2proc_data <= '0;
      for (int unsigned t = 1; t <= NTAGS; t++)
        count[TAG_W'(t)] <= '0;
    end else begin
      mem2proc_tag <= ret_found ? ret_tag : '0;
      if (ret_found)
        mem2proc_data <= snap[ret_tag];
      // The tag stays busy through its return cycle and frees on the edge that ends it.
      for (int unsigned t = 1; t <= NTAGS; t++) begin
        if (count[TAG_W'(t)] != '0)
          count[TAG_W'(t)] <= count[TAG_W'(t)] - CNT_W'(1);
        if (count[TAG_W'(t)] == CNT_W'(1))
          busy[TAG_W'(t)] <= 1'b0;
      end
      if (load_acc) begin
        busy[free_tag]  <= 1'b1;
        count[free_tag] <= CNT_W'(MEM_LATENCY);
      end
    end
  end

  // Storage is deliberately left out of the reset domain.
  always_ff @(posedge clock) begin
    if (store_acc)
      mem[word_idx] <= proc2mem_data;
    if (load_acc)
      snap[free_tag] <= mem[word_idx];
  end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      err_misaligned <= 1'b0;
    else if ((proc2mem_command == BUS_LOAD || proc2mem_command == BUS_STORE) && !addr_ok)
      err_misaligned <= 1'b1;
  end
`else
  assign err_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table for responses, scoreboard queue for load returns.
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT = 16;

  typedef struct {
    BUS_COMMAND  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic        clock;
  logic        reset;
  BUS_COMMAND  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic        err_misaligned;

  exp_t        sbq[$];
  logic [63:0] ref_mem[int];
  logic [63:0] last_data;
  vec_t        vecs[10];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  mem_responder #(.MEM_LATENCY(LAT), .MEM_DEPTH(4096)) dut (
    .clock            (clock),
    .reset            (reset),
    .proc2mem_command (proc2mem_command),
    .proc2mem_addr    (proc2mem_addr),
    .proc2mem_data    (proc2mem_data),
    .mem2proc_response(mem2proc_response),
    .mem2proc_data    (mem2proc_data),
    .mem2proc_tag     (mem2proc_tag),
    .err_misaligned   (err_misaligned)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) & 32'h0000_0FFF);
  endfunction

  task automatic drive(input BUS_COMMAND c, input logic [31:0] a, input logic [63:0] d,
                       input logic [3:0] er, input string nm);
    @(negedge clock);
    proc2mem_command = c;
    proc2mem_addr    = a;
    proc2mem_data    = d;
    #1;
    check(nm, {60'd0, mem2proc_response}, {60'd0, er});
    if (er != 4'd0) begin
      if (c == BUS_STORE)
        ref_mem[widx(a)] = d;
      else if (c == BUS_LOAD)
        sbq.push_back('{tag: er, data: ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 'x, due: cyc + LAT});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(BUS_NONE, 32'h0, 64'h0, 4'd0, "idle_resp");
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    proc2mem_command = BUS_NONE;
    sbq.delete();
    last_data = '0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  // Return monitor: every non-reset cycle either matches the queue head or must be idle.
  always @(negedge clock) begin
    if (reset) begin
      last_data = '0;
    end else begin
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_return: tag %0d due cycle %0d never seen", sbq[0].tag, sbq[0].due);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        n_tests++;
        if (mem2proc_tag !== sbq[0].tag || mem2proc_data !== sbq[0].data) begin
          n_fail++;
          $display("FAIL load_return: got tag %0d data %h expected tag %0d data %h (cycle %0d)",
                   mem2proc_tag, mem2proc_data, sbq[0].tag, sbq[0].data, cyc);
        end
        last_data = sbq[0].data;
        void'(sbq.pop_front());
      end else if (mem2proc_tag !== 4'd0 || mem2proc_data !== last_data) begin
        n_tests++;
        n_fail++;
        $display("FAIL idle_return: got tag %0d data %h expected tag 0 data %h (cycle %0d)",
                 mem2proc_tag, mem2proc_data, last_data, cyc);
      end
    end
  end

  initial begin
    vecs[0] = '{BUS_STORE, 32'h0000_0100, 64'hDEADBEEF_00000001, 4'd1};
    vecs[1] = '{BUS_LOAD,  32'h0000_0100, 64'h0,                 4'd1};
    vecs[2] = '{BUS_STORE, 32'h0000_8000, 64'h01234567_89ABCDEF, 4'd2};
    vecs[3] = '{BUS_LOAD,  32'h0000_0000, 64'h0,                 4'd2};
    vecs[4] = '{BUS_STORE, 32'h0000_0200, 64'hAAAAAAAA_55555555, 4'd3};
    vecs[5] = '{BUS_LOAD,  32'h0000_0200, 64'h0,                 4'd3};
    vecs[6] = '{BUS_STORE, 32'h0000_0200, 64'hBBBBBBBB_CCCCCCCC, 4'd4};
    vecs[7] = '{BUS_LOAD,  32'h0000_0200, 64'h0,                 4'd4};
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    vecs[8] = '{BUS_LOAD,  32'h0000_0104, 64'h0,                 4'd0};
`else
    vecs[8] = '{BUS_LOAD,  32'h0000_0104, 64'h0,                 4'd5};
`endif
    vecs[9] = '{BUS_NONE,  32'h0000_0100, 64'h0,                 4'd0};

    reset            = 1'b1;
    last_data        = '0;
    proc2mem_command = BUS_LOAD;
    proc2mem_addr    = 32'h100;
    proc2mem_data    = '0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_resp", {60'd0, mem2proc_response}, 64'd0);
    check("reset_tag",  {60'd0, mem2proc_tag},      64'd0);
    check("reset_data", mem2proc_data,              64'd0);
    check("reset_err",  {63'd0, err_misaligned},    64'd0);
    proc2mem_command = BUS_NONE;
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      drive(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].exp_resp, $sformatf("vec%0d_resp", i));
    idle(20);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    check("err_sticky", {63'd0, err_misaligned}, 64'd1);
`else
    check("err_tied",   {63'd0, err_misaligned}, 64'd0);
`endif
    pulse_reset(2);
    #1;
    check("err_after_reset", {63'd0, err_misaligned}, 64'd0);

    // Exhaust all tags; tag 1 returns in cycle 16 and is reusable only from cycle 17.
    for (int k = 0; k < 16; k++)
      drive(BUS_LOAD, 32'h100, 64'h0, (k < 15) ? 4'(k + 1) : 4'd0, $sformatf("burst%0d_resp", k));
    drive(BUS_STORE, 32'h300, 64'h0F0F0F0F_F0F0F0F0, 4'd1, "store_all_busy_resp");
    drive(BUS_LOAD,  32'h300, 64'h0, 4'd1, "reuse_tag1_resp");
    idle(20);

    // Outstanding loads discarded by a one-cycle reset.
    for (int k = 0; k < 4; k++)
      drive(BUS_LOAD, 32'h200, 64'h0, 4'(k + 1), $sformatf("inflight%0d_resp", k));
    idle(2);
    pulse_reset(1);
    idle(20);
    drive(BUS_LOAD, 32'h0, 64'h0, 4'd1, "post_reset_load_resp");
    idle(20);

    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
